// File: rtl/rsa_exp_sequencer_pkg.sv
// rtl/rsa_exp_sequencer_pkg.sv - shared state encoding and defaults for the modular exponentiation sequencer
package rsa_exp_sequencer_pkg;

    localparam int DEFAULT_MOD_WIDTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        CONV_REQ,
        CONV_WAIT,
        DONE
    } RSAExpState;

    function automatic logic is_req(RSAExpState s);
        return (s == MUL_REQ) || (s == SQR_REQ) || (s == CONV_REQ);
    endfunction

    function automatic logic is_wait(RSAExpState s);
        return (s == MUL_WAIT) || (s == SQR_WAIT) || (s == CONV_WAIT);
    endfunction

endpackage

// File: rtl/rsa_exp_sequencer_if.sv
// rtl/rsa_exp_sequencer_if.sv - request, result and Montgomery multiplier handshakes of the sequencer
interface rsa_exp_sequencer_if #(parameter int MOD_WIDTH = 256);

    typedef struct packed {
        logic [MOD_WIDTH-1:0] msg_mont;
        logic [MOD_WIDTH-1:0] one_mont;
        logic [MOD_WIDTH-1:0] key;
        logic [MOD_WIDTH-1:0] modulus;
    } RSAExpIn;

    typedef struct packed {
        logic [MOD_WIDTH-1:0] a;
        logic [MOD_WIDTH-1:0] b;
        logic [MOD_WIDTH-1:0] modulus;
    } MontgomeryIn;

    typedef logic [MOD_WIDTH-1:0] MontgomeryOut;

    logic                 i_valid;
    logic                 i_ready;
    RSAExpIn              i_in;
    logic                 o_valid;
    logic                 o_ready;
    logic [MOD_WIDTH-1:0] o_out;
    logic                 mont_valid;
    logic                 mont_ready;
    MontgomeryIn          mont_in;
    logic                 mont_o_valid;
    logic                 mont_o_ready;
    MontgomeryOut         mont_out;

    modport slave (
        input  i_valid, i_in, o_ready, mont_ready, mont_o_valid, mont_out,
        output i_ready, o_valid, o_out, mont_valid, mont_in, mont_o_ready
    );

    modport master (
        output i_valid, i_in, o_ready, mont_ready, mont_o_valid, mont_out,
        input  i_ready, o_valid, o_out, mont_valid, mont_in, mont_o_ready
    );

endinterface

// File: rtl/rsa_exp_sequencer_exp_bit_scanner.sv
// rtl/rsa_exp_sequencer_exp_bit_scanner.sv - key shift register and bit index for right-to-left exponent scanning
module exp_bit_scanner #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [MOD_WIDTH-1:0] key,
    output logic                 cur_bit,
    output logic                 next_bit,
    output logic                 last,
    output logic                 next_last
);

    localparam int IDX_W = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MOD_WIDTH - 1);

    logic [MOD_WIDTH-1:0] key_sh;
    logic [IDX_W-1:0]     idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sh <= '0;
            idx    <= '0;
        end else if (load) begin
            key_sh <= key;
            idx    <= '0;
        end else if (advance) begin
            key_sh <= key_sh >> 1;
            idx    <= idx + 1'b1;
        end
    end

    // next_* let the controller skip an empty multiply without spending a cycle
    assign cur_bit   = key_sh[0];
    assign next_bit  = key_sh[1];
    assign last      = (idx == LAST_IDX);
    assign next_last = (idx == LAST_IDX - 1'b1);

endmodule

// File: rtl/rsa_exp_sequencer.sv
// rtl/rsa_exp_sequencer.sv - square-and-multiply controller around one Montgomery multiplier; option RSA_EXP_CONST_TIME_EN
module rsa_exp_sequencer
    import rsa_exp_sequencer_pkg::*;
#(
    parameter int MOD_WIDTH = DEFAULT_MOD_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    rsa_exp_sequencer_if.slave   bus
);

    RSAExpState           state;
    logic [MOD_WIDTH-1:0] result;
    logic [MOD_WIDTH-1:0] base;
    logic [MOD_WIDTH-1:0] modulus;
    logic                 cur_bit;
    logic                 next_bit;
    logic                 last;
    logic                 next_last;
    logic                 load;
    logic                 advance;

    assign load    = (state == IDLE) && bus.i_valid;
    assign advance = (state == SQR_WAIT) && bus.mont_o_valid;

    exp_bit_scanner #(.MOD_WIDTH(MOD_WIDTH)) u_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .advance   (advance),
        .key       (bus.i_in.key),
        .cur_bit   (cur_bit),
        .next_bit  (next_bit),
        .last      (last),
        .next_last (next_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            base    <= '0;
            modulus <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_valid) begin
                    result  <= bus.i_in.one_mont;
                    base    <= bus.i_in.msg_mont;
                    modulus <= bus.i_in.modulus;
`ifdef RSA_EXP_CONST_TIME_EN
                    state   <= MUL_REQ;
`else
                    // a zero key needs no squares at all, only the conversion
                    if (bus.i_in.key == '0)   state <= CONV_REQ;
                    else if (bus.i_in.key[0]) state <= MUL_REQ;
                    else                      state <= SQR_REQ;
`endif
                end
                MUL_REQ:  if (bus.mont_ready) state <= MUL_WAIT;
                MUL_WAIT: if (bus.mont_o_valid) begin
`ifdef RSA_EXP_CONST_TIME_EN
                    if (cur_bit) result <= bus.mont_out;
`else
                    result <= bus.mont_out;
`endif
                    state <= last ? CONV_REQ : SQR_REQ;
                end
                SQR_REQ:  if (bus.mont_ready) state <= SQR_WAIT;
                SQR_WAIT: if (bus.mont_o_valid) begin
                    base <= bus.mont_out;
`ifdef RSA_EXP_CONST_TIME_EN
                    state <= MUL_REQ;
`else
                    if (next_bit)       state <= MUL_REQ;
                    else if (next_last) state <= CONV_REQ;
                    else                state <= SQR_REQ;
`endif
                end
                CONV_REQ:  if (bus.mont_ready) state <= CONV_WAIT;
                CONV_WAIT: if (bus.mont_o_valid) begin
                    result <= bus.mont_out;
                    state  <= DONE;
                end
                DONE:    if (bus.o_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_ready      = (state == IDLE);
    assign bus.o_valid      = (state == DONE);
    assign bus.o_out        = result;
    assign bus.mont_valid   = is_req(state);
    assign bus.mont_o_ready = is_wait(state);
    assign bus.mont_in      = '{
        a:       (state == SQR_REQ)  ? base : result,
        b:       (state == CONV_REQ) ? MOD_WIDTH'(1) : base,
        modulus: modulus
    };

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// tb/tb_rsa_exp_sequencer.sv - scoreboard bench with a Montgomery multiplier model, MOD_WIDTH=8, N=187
module tb_rsa_exp_sequencer;
    import rsa_exp_sequencer_pkg::*;

    localparam int W   = 8;
    localparam int N   = 187;
    localparam int ONE = 69;

`ifdef RSA_EXP_CONST_TIME_EN
    localparam int TX_K3 = 16, TX_K0 = 16, TX_KFF = 16;
`else
    localparam int TX_K3 = 10, TX_K0 = 1, TX_KFF = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsa_exp_sequencer_if #(.MOD_WIDTH(W)) bus();

    rsa_exp_sequencer #(.MOD_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int txn_cnt = 0;
    bit stall_en = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(string name, int act, int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int redc(int a, int b, int m);
        int t;
        t = a * b;
        for (int i = 0; i < W; i++) begin
            if ((t & 1) != 0) t = t + m;
            t = t >> 1;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    // Montgomery multiplier model: one transaction at a time, optional random stalls
    initial begin : mont_model
        bit busy, req_fire, rsp_fire, held;
        int delay, res, pa, pb, pm;
        logic [W-1:0] ha, hb;
        busy = 0; req_fire = 0; rsp_fire = 0; held = 0; delay = 0; res = 0;
        pa = 0; pb = 0; pm = 0; ha = '0; hb = '0;
        bus.mont_ready   = 1'b0;
        bus.mont_o_valid = 1'b0;
        bus.mont_out     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; req_fire = 0; rsp_fire = 0; held = 0;
                bus.mont_ready   = 1'b0;
                bus.mont_o_valid = 1'b0;
            end else begin
                if (rsp_fire) begin
                    bus.mont_o_valid = 1'b0;
                    busy = 0;
                end
                if (req_fire) begin
                    busy  = 1;
                    res   = redc(pa, pb, pm);
                    delay = stall_en ? int'($urandom_range(0, 3)) : 0;
                end
                if (busy && !bus.mont_o_valid) begin
                    if (delay == 0) begin
                        bus.mont_o_valid = 1'b1;
                        bus.mont_out     = W'(res);
                    end else begin
                        delay--;
                    end
                end
                bus.mont_ready = !busy && (!stall_en || ($urandom_range(0, 1) == 1));
                if (held) begin
                    check("mont_valid_held", int'(bus.mont_valid), 1);
                    check("mont_a_stable", int'(bus.mont_in.a), int'(ha));
                    check("mont_b_stable", int'(bus.mont_in.b), int'(hb));
                end
                req_fire = bus.mont_valid && bus.mont_ready;
                rsp_fire = bus.mont_o_valid && bus.mont_o_ready;
                if (req_fire) begin
                    pa = int'(bus.mont_in.a);
                    pb = int'(bus.mont_in.b);
                    pm = int'(bus.mont_in.modulus);
                    txn_cnt++;
                    check("mont_modulus", pm, N);
                end
                held = bus.mont_valid && !req_fire;
                ha   = bus.mont_in.a;
                hb   = bus.mont_in.b;
            end
        end
    end

    // Result monitor: pops the scoreboard on every output handshake
    initial begin : monitor
        bit held;
        logic [W-1:0] hval;
        logic [W-1:0] want;
        held = 0; hval = '0; want = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held) begin
                    check("o_valid_held", int'(bus.o_valid), 1);
                    check("o_out_held", int'(bus.o_out), int'(hval));
                end
                if (bus.o_valid) begin
                    check("i_ready_low_in_done", int'(bus.i_ready), 0);
                    if (bus.o_ready) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_output: got %0d, expected no output", bus.o_out);
                        end else begin
                            want = exp_q.pop_front();
                            check("o_out", int'(bus.o_out), int'(want));
                        end
                        done_cnt++;
                        held = 0;
                    end else begin
                        held = 1;
                        hval = bus.o_out;
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    task automatic set_req(int mm, int key);
        bus.i_in.msg_mont = W'(mm);
        bus.i_in.one_mont = W'(ONE);
        bus.i_in.key      = W'(key);
        bus.i_in.modulus  = W'(N);
    endtask

    // Called right at a falling edge; returns at the falling edge after the accept
    task automatic wait_accept(string name);
        int n;
        n = 0;
        #1;
        while (!bus.i_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.i_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: waited %0d cycles, required i_ready within 2000", name, n);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(string name, int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done_cnt, target);
    endtask

    task automatic run_req(string name, int mm, int key, int expv, int exp_txn, int hold);
        int n;
        txn_cnt = 0;
        set_req(mm, key);
        bus.i_valid = 1'b1;
        exp_q.push_back(W'(expv));
        wait_accept(name);
        bus.i_valid = 1'b0;
        check({name, "_busy"}, int'(bus.i_ready), 0);
        n = 0;
        while (!bus.o_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (hold) @(negedge clk);
        bus.o_ready = 1'b1;
        wait_done(name, done_cnt + 1);
        bus.o_ready = 1'b0;
        check({name, "_txns"}, txn_cnt, exp_txn);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time exceeded, required completion before 600000");
        fails++;
        tests++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : main
        int n, base_cnt;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        set_req(0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_i_ready", int'(bus.i_ready), 1);
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_mont_valid", int'(bus.mont_valid), 0);
        check("rst_mont_o_ready", int'(bus.mont_o_ready), 0);
        check("rst_o_out", int'(bus.o_out), 0);
        @(negedge clk);

        run_req("k3", 158, 8'h03, 125, TX_K3, 0);
        run_req("k0", 158, 8'h00, 1, TX_K0, 0);
        run_req("kff", 138, 8'hFF, 43, TX_KFF, 2);

        stall_en = 1;
        run_req("k3_stall", 158, 8'h03, 125, TX_K3, 20);
        run_req("kff_stall", 138, 8'hFF, 43, TX_KFF, 5);
        stall_en = 0;

        // reset in the middle of the first square
        set_req(138, 8'hFF);
        bus.i_valid = 1'b1;
        wait_accept("rst_mid");
        bus.i_valid = 1'b0;
        n = 0;
        while (dut.state != SQR_WAIT && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_sqr_wait", int'(dut.state == SQR_WAIT), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mont_valid", int'(bus.mont_valid), 0);
        check("rst_mid_mont_o_ready", int'(bus.mont_o_ready), 0);
        check("rst_mid_i_ready", int'(bus.i_ready), 1);
        check("rst_mid_o_valid", int'(bus.o_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req("after_rst", 158, 8'h03, 125, TX_K3, 0);

        // back-to-back with i_valid held high
        base_cnt = done_cnt;
        set_req(158, 8'h03);
        exp_q.push_back(W'(125));
        bus.i_valid = 1'b1;
        wait_accept("b2b_first");
        set_req(138, 8'hFF);
        exp_q.push_back(W'(43));
        bus.o_ready = 1'b1;
        wait_done("b2b_first", base_cnt + 1);
        wait_accept("b2b_second");
        bus.i_valid = 1'b0;
        wait_done("b2b_second", base_cnt + 2);
        bus.o_ready = 1'b0;
        check("b2b_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
